// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-add multiplier and its push-button front
// end: FSM state encoding, default sizing constants and small elaboration-time
// helpers for register widths.
// No ports (package).
// ---------------------------------------------------------------------------
package mult_pkg;

   // Multiplier control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default operand width; the product (2*WIDTH) feeds an 8-bit display
   localparam int DEFAULT_WIDTH           = 4;

   // 10 ms of stable level at 100 MHz before a button change is accepted
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

   // Metastability synchronizer depth for the raw button
   localparam int SYNC_STAGES             = 2;

   // Bits needed for the iteration index 0..w-1 (at least one bit)
   function automatic int iter_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   // Bits needed for the debounce counter 0..cycles-1 (at least one bit)
   function automatic int counter_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Cleans up a raw, bouncing push-button: a synchronizer brings it into the
// clock_100Mhz domain, a stability counter accepts a level change only after
// DEBOUNCE_CYCLES consecutive clocks of disagreement, and an edge detector
// produces one pulse per accepted press.
//
// Ports:
//   clock_100Mhz  in   system clock
//   reset         in   synchronous, active-high
//   btn_raw       in   raw button, asynchronous, may bounce
//   btn_level     out  debounced button level
//   btn_rise      out  one-cycle pulse on a debounced rising edge
// ---------------------------------------------------------------------------
module button_debounce
   import mult_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clock_100Mhz,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise
);

   localparam int CNT_W = counter_width(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [CNT_W-1:0]       cnt_reg;
   logic                   level_reg;
   logic                   level_prev_reg;
   logic                   synced;

   assign synced = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         sync_reg       <= '0;
         cnt_reg        <= '0;
         level_reg      <= 1'b0;
         level_prev_reg <= 1'b0;
      end else begin
         sync_reg       <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
         level_prev_reg <= level_reg;
         // Count only while the synchronized input disagrees with the accepted
         // level; any agreeing cycle restarts the window, so short glitches
         // never reach the flip threshold.
         if (synced != level_reg) begin
            if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               level_reg <= synced;
               cnt_reg   <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else begin
            cnt_reg <= '0;
         end
      end
   end

   assign btn_level = level_reg;
   assign btn_rise  = level_reg & ~level_prev_reg;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
// Unsigned WIDTH x WIDTH multiplier started by a debounced push-button.
// One multiplier bit is consumed per clock (shift-add); the result is held in
// a register so the downstream seven-segment display keeps showing the last
// product between computations.
//
// Ports:
//   clock_100Mhz  in   system clock, 100 MHz
//   reset         in   synchronous, active-high
//   operand_a     in   multiplicand (slide switches, sampled at load only)
//   operand_b     in   multiplier   (slide switches, sampled at load only)
//   start_btn     in   raw push-button, may bounce
//   product       out  last completed product, registered
//   busy          out  high while the iteration is running
//   done          out  one-cycle pulse when product updates
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH           = DEFAULT_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                 clock_100Mhz,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   input  logic                 start_btn,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 done
);

   localparam int PW     = 2 * WIDTH;
   localparam int ITER_W = iter_width(WIDTH);

   state_t             state_reg;
   logic [PW-1:0]      mcand_reg;
   logic [PW-1:0]      acc_reg;
   logic [PW-1:0]      product_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [ITER_W-1:0]  iter_reg;
   logic               busy_reg;
   logic               done_reg;

   logic               start_pulse;
   logic               btn_level_unused;
   logic [PW-1:0]      acc_next;
   logic               last_iter;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .btn_raw      (start_btn),
      .btn_level    (btn_level_unused),
      .btn_rise     (start_pulse)
   );

   // Accumulator value after this cycle's partial product; also the final
   // result on the last iteration, so the last add is not lost.
   assign acc_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
   assign last_iter = (iter_reg == ITER_W'(WIDTH - 1));

   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         state_reg   <= IDLE;
         mcand_reg   <= '0;
         acc_reg     <= '0;
         product_reg <= '0;
         mplier_reg  <= '0;
         iter_reg    <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start_pulse) begin
                  // Operands are captured here only; later switch
                  // movement cannot disturb a running computation.
                  mcand_reg <= PW'(operand_a);
                  mplier_reg <= operand_b;
                  acc_reg    <= '0;
                  iter_reg   <= '0;
                  busy_reg   <= 1'b1;
                  state_reg  <= CALC;
               end
            end

            CALC: begin
               // start_pulse is deliberately not looked at here or in DONE.
               acc_reg    <= acc_next;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               iter_reg   <= iter_reg + 1'b1;
               if (last_iter) begin
                  product_reg <= acc_next;
                  busy_reg    <= 1'b0;
                  done_reg    <= 1'b1;
                  state_reg   <= DONE;
               end
            end

            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign product = product_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
// Self-checking bench for seq_shift_add_multiplier with a short debounce
// window. Expected products come from plain a*b arithmetic; expected timing
// comes from the documented latency chain (synchronizer, debounce window,
// one load cycle, WIDTH iterations).
// ---------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

   localparam int WIDTH = 4;
   localparam int DEB   = 4;
   localparam int PW    = 2 * WIDTH;
   // Clock edges from raw press to the first cycle showing done/product:
   // 2 synchronizer stages + DEB debounce edges + 1 load edge + WIDTH iterations
   localparam int PRESS_TO_DONE = 2 + DEB + 1 + WIDTH;

   logic              clock_100Mhz = 1'b0;
   logic              reset;
   logic [WIDTH-1:0]  operand_a;
   logic [WIDTH-1:0]  operand_b;
   logic              start_btn;
   logic [PW-1:0]     product;
   logic              busy;
   logic              done;

   int compared   = 0;
   int mismatched = 0;

   // Running totals of observed done pulses and busy cycles
   int done_seen   = 0;
   int busy_cycles = 0;

   seq_shift_add_multiplier #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .start_btn    (start_btn),
      .product      (product),
      .busy         (busy),
      .done         (done)
   );

   always #5 clock_100Mhz = ~clock_100Mhz;

   always @(posedge clock_100Mhz) begin
      #1;
      if (done) done_seen++;
      if (busy) busy_cycles++;
   end

   // Reference model: the product is simply the arithmetic product.
   function automatic logic [PW-1:0] ref_product(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      int unsigned p;
      p = int'(a) * int'(b);
      return PW'(p);
   endfunction

   // Stimulus: hold the button for 'hold' clocks, release, then let
   // everything settle. Reports the first cycle (counted from the press)
   // at which done was seen and how many done pulses occurred.
   task automatic press(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int hold, output int first_done, output int n_done);
      int d0;
      first_done = -1;
      d0 = done_seen;
      operand_a = a;
      operand_b = b;
      start_btn = 1'b1;
      for (int k = 1; k <= hold + 2 * DEB + WIDTH + 12; k++) begin
         @(negedge clock_100Mhz);
         if (k == hold) start_btn = 1'b0;
         if (done && first_done < 0) first_done = k;
      end
      n_done = done_seen - d0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      start_btn = 1'b0;
      operand_a = '0;
      operand_b = '0;
      repeat (3) @(negedge clock_100Mhz);
      reset = 1'b0;
      @(negedge clock_100Mhz);
      compared++;
      if (product !== '0) begin
         mismatched++;
         $display("FAIL reset_product: got %0d expected 0", product);
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      compared++;
      if (done !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      $display("test_reset: product=%0d busy=%b done=%b", product, busy, done);
   endtask

   task automatic test_max_product();
      int first_done, n_done, b0;
      logic [PW-1:0] exp_p;
      exp_p = ref_product(4'd15, 4'd15);
      b0 = busy_cycles;
      press(4'd15, 4'd15, 20, first_done, n_done);
      compared++;
      if (product !== exp_p) begin
         mismatched++;
         $display("FAIL max_product: got %0d expected %0d", product, exp_p);
      end
      compared++;
      if (first_done != PRESS_TO_DONE) begin
         mismatched++;
         $display("FAIL max_latency: done at cycle %0d expected %0d", first_done, PRESS_TO_DONE);
      end
      compared++;
      if (n_done != 1) begin
         mismatched++;
         $display("FAIL max_done_count: got %0d expected 1", n_done);
      end
      compared++;
      if (busy_cycles - b0 != WIDTH) begin
         mismatched++;
         $display("FAIL max_busy_cycles: got %0d expected %0d", busy_cycles - b0, WIDTH);
      end
      $display("test_max_product: a=15 b=15 product=%0d done_at=%0d dones=%0d", product, first_done, n_done);
   endtask

   task automatic test_zero_and_hold();
      int first_done, n_done;
      press(4'd0, 4'd9, 20, first_done, n_done);
      compared++;
      if (product !== ref_product(4'd0, 4'd9) || n_done != 1) begin
         mismatched++;
         $display("FAIL zero_operand: got product %0d dones %0d expected 0 and 1", product, n_done);
      end
      $display("test_zero: a=0 b=9 product=%0d dones=%0d", product, n_done);
      press(4'd7, 4'd1, 20, first_done, n_done);
      compared++;
      if (product !== ref_product(4'd7, 4'd1) || n_done != 1) begin
         mismatched++;
         $display("FAIL seven_times_one: got product %0d dones %0d expected 7 and 1", product, n_done);
      end
      $display("test_seven: a=7 b=1 product=%0d dones=%0d", product, n_done);
      // Switches move with no press: display must keep the old result
      operand_a = 4'd15;
      operand_b = 4'd15;
      repeat (20) @(negedge clock_100Mhz);
      compared++;
      if (product !== ref_product(4'd7, 4'd1)) begin
         mismatched++;
         $display("FAIL hold_product: got %0d expected 7", product);
      end
      $display("test_hold: product=%0d after switch change", product);
   endtask

   task automatic test_bounce();
      int d0, b0;
      logic [WIDTH-1:0] a, b;
      a = WIDTH'($urandom_range(1, 15));
      b = WIDTH'($urandom_range(1, 15));
      operand_a = a;
      operand_b = b;
      d0 = done_seen;
      b0 = busy_cycles;
      for (int g = 0; g < 3; g++) begin
         start_btn = 1'b1;
         repeat (DEB - 1) @(negedge clock_100Mhz);
         start_btn = 1'b0;
         repeat (3) @(negedge clock_100Mhz);
      end
      repeat (10) @(negedge clock_100Mhz);
      compared++;
      if (done_seen != d0 || busy_cycles != b0) begin
         mismatched++;
         $display("FAIL bounce_rejected: got %0d dones %0d busy cycles expected 0 and 0",
                  done_seen - d0, busy_cycles - b0);
      end
      start_btn = 1'b1;
      repeat (100) @(negedge clock_100Mhz);
      compared++;
      if (done_seen - d0 != 1 || product !== ref_product(a, b)) begin
         mismatched++;
         $display("FAIL bounce_stable: got %0d dones product %0d expected 1 and %0d",
                  done_seen - d0, product, ref_product(a, b));
      end
      start_btn = 1'b0;
      repeat (2 * DEB + 8) @(negedge clock_100Mhz);
      $display("test_bounce: a=%0d b=%0d product=%0d dones=%0d", a, b, product, done_seen - d0);
   endtask

   task automatic test_ignore_during_calc();
      int d0, b0, waited;
      d0 = done_seen;
      b0 = busy_cycles;
      operand_a = 4'd6;
      operand_b = 4'd5;
      start_btn = 1'b1;
      waited = 0;
      while (!busy && waited < 40) begin
         @(negedge clock_100Mhz);
         waited++;
      end
      compared++;
      if (!busy) begin
         mismatched++;
         $display("FAIL ignore_start: busy not seen within 40 cycles");
      end
      // Switches change and the button is re-pressed while computing
      operand_a = 4'd15;
      operand_b = 4'd15;
      start_btn = 1'b0;
      @(negedge clock_100Mhz);
      start_btn = 1'b1;
      repeat (30) @(negedge clock_100Mhz);
      start_btn = 1'b0;
      repeat (2 * DEB + 8) @(negedge clock_100Mhz);
      compared++;
      if (product !== ref_product(4'd6, 4'd5)) begin
         mismatched++;
         $display("FAIL ignore_product: got %0d expected 30", product);
      end
      compared++;
      if (done_seen - d0 != 1 || busy_cycles - b0 != WIDTH) begin
         mismatched++;
         $display("FAIL ignore_single_run: got %0d dones %0d busy cycles expected 1 and %0d",
                  done_seen - d0, busy_cycles - b0, WIDTH);
      end
      $display("test_ignore: a=6 b=5 product=%0d dones=%0d", product, done_seen - d0);
   endtask

   task automatic test_reset_mid_calc();
      int first_done, n_done, d0, waited;
      press(4'd15, 4'd15, 20, first_done, n_done);
      compared++;
      if (product !== ref_product(4'd15, 4'd15)) begin
         mismatched++;
         $display("FAIL midreset_setup: got %0d expected 225", product);
      end
      d0 = done_seen;
      start_btn = 1'b1;
      waited = 0;
      while (!busy && waited < 40) begin
         @(negedge clock_100Mhz);
         waited++;
      end
      @(negedge clock_100Mhz);          // second CALC cycle
      reset     = 1'b1;
      start_btn = 1'b0;
      @(negedge clock_100Mhz);
      compared++;
      if (product !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("FAIL midreset_state: got product %0d busy %b done %b expected 0 0 0",
                  product, busy, done);
      end
      reset = 1'b0;
      repeat (20) @(negedge clock_100Mhz);
      compared++;
      if (done_seen != d0 || product !== '0) begin
         mismatched++;
         $display("FAIL midreset_no_done: got %0d dones product %0d expected 0 and 0",
                  done_seen - d0, product);
      end
      press(4'd3, 4'd4, 20, first_done, n_done);
      compared++;
      if (product !== ref_product(4'd3, 4'd4) || n_done != 1) begin
         mismatched++;
         $display("FAIL midreset_recover: got product %0d dones %0d expected 12 and 1",
                  product, n_done);
      end
      $display("test_reset_mid_calc: after recovery a=3 b=4 product=%0d", product);
   endtask

   task automatic test_random();
      int first_done, n_done, hold;
      logic [WIDTH-1:0] a, b;
      for (int i = 0; i < 8; i++) begin
         a    = WIDTH'($urandom_range(0, 15));
         b    = WIDTH'($urandom_range(0, 15));
         hold = int'($urandom_range(DEB + 4, 30));
         press(a, b, hold, first_done, n_done);
         compared++;
         if (product !== ref_product(a, b) || n_done != 1 || first_done != PRESS_TO_DONE) begin
            mismatched++;
            $display("FAIL random_%0d: a=%0d b=%0d got product %0d dones %0d at %0d expected %0d 1 at %0d",
                     i, a, b, product, n_done, first_done, ref_product(a, b), PRESS_TO_DONE);
         end
         $display("test_random[%0d]: a=%0d b=%0d product=%0d done_at=%0d", i, a, b, product, first_done);
      end
   endtask

   initial begin
      test_reset();
      test_max_product();
      test_zero_and_hold();
      test_bounce();
      test_ignore_during_calc();
      test_reset_mid_calc();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
